fifo_if_buf: RTL and testbench
==============================

# fifo_if_buf

Parametrised MCU-to-USB_CDC FIFO interface with configurable-depth IN and OUT buffers, replacing the single-byte holding registers of the previous generation. It sits between an MCU bus (sel/read/write/addr strobes) and the USB_CDC byte-stream FIFO ports. It exposes level and status registers, keeps per-byte IRQ pulses, and adds a maskable, sticky interrupt controller.

## Interface
- IN_DEPTH, 16: IN buffer entries, power of two, 2..128.
- OUT_DEPTH, 16: OUT buffer entries, power of two, 2..128.
- clk_i  in  1  single clock; all logic on rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- sel_i  in  1  MCU chip select; all accesses require sel_i=1.
- read_i  in  1  MCU read strobe; one access per cycle high.
- write_i  in  1  MCU write strobe; one access per cycle high.
- addr_i  in  3  register address.
- data_i  in  8  MCU write data.
- data_o  out  8  MCU read data, registered.
- in_irq_o  out  1  one-cycle pulse per IN byte consumed by USB_CDC.
- out_irq_o  out  1  one-cycle pulse per OUT byte accepted from USB_CDC.
- irq_o  out  1  level interrupt, |(flags & enable).
- in_data_o  out  8  IN buffer head byte.
- in_valid_o  out  1  IN buffer not empty.
- in_ready_i  in  1  USB_CDC consumes the head when in_valid_o&in_ready_i.
- out_data_i  in  8  USB_CDC OUT byte.
- out_valid_i  in  1  out_data_i valid.
- out_ready_o  out  1  OUT buffer not full; byte pushed when out_valid_i&out_ready_o.

## Operation
- Register map (R = read, W = write):
  - 0 R STATUS: {4'b0, out_full, out_empty, in_full, in_empty}.
  - 1 W IN_DATA: push data_i to IN buffer.
  - 2 R IN_LEVEL: IN occupancy, zero-extended.
  - 3 R OUT_DATA: returns OUT head and pops it.
  - 4 R OUT_LEVEL: OUT occupancy, zero-extended.
  - 5 R/W IRQ_EN: bits [3:0] enable; [7:4] read 0.
  - 6 R/W1C IRQ_FLAGS: bit0 IN_EMPTY_EV, bit1 OUT_DATA_EV, bit2 IN_OVF, bit3 OUT_UNF.
  - 7 and unused bits: read 0, writes ignored.
- Buffers: circular RAM with rd/wr pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy counters are $clog2(DEPTH)+1 bits, so DEPTH=128 yields level 128 (0x80).
- IN push: a write to addr 1 when in_full=1 is dropped, and sets IN_OVF. Fullness is sampled before the cycle, so a same-cycle consume does not rescue the write.
- IN pop: on in_valid_o&in_ready_i, pulse in_irq_o. If this empties the buffer, set IN_EMPTY_EV.
- OUT push: on out_valid_i&out_ready_o, pulse out_irq_o and set OUT_DATA_EV.
- OUT pop: a read of addr 3 when out_empty=1 returns 0x00, does not pop, and sets OUT_UNF.
- Simultaneous push and pop on one buffer: level unchanged, both pointers advance.
- Flags: a W1C write clears the bits written as 1. A flag set event in the same cycle wins over the clear.
- Reset: pointers and levels 0, IRQ_EN 0, flags 0, data_o 0x00, in_valid_o 0, in_data_o 0x00 (RAM head reset or masked), out_ready_o 1, all irq outputs 0.

## Timing
- Read latency 1: data_o is updated on the clock edge after a sel&read cycle and holds until the next read.
- Write effect is visible in status/levels on the cycle after the strobe.
- in_valid_o and out_ready_o are derived from registered counters, so they are glitch-free. in_valid_o rises 1 cycle after the IN_DATA write.
- in_irq_o and out_irq_o assert in the cycle after the handshake edge, for exactly 1 cycle.
- irq_o is combinational from the registered flags and enables; it rises the cycle after the event.
- Back-to-back accesses every cycle are supported at full rate on both sides.

## Configuration
- FIFO_IF_BUF_IRQ_EN defined: IRQ_EN and IRQ_FLAGS registers and irq_o are implemented as specified.
- Not defined: addr 5/6 read 0x00, writes to them are ignored, irq_o is tied 0, and flag logic is removed. in_irq_o and out_irq_o remain.

## Test plan
- Reset mid-stream: push 3 IN bytes, assert rstn_i=0 -> in_valid_o=0, IN_LEVEL=0, out_ready_o=1 immediately. After release, STATUS reads 0x05.
- IN fill and overflow (IN_DEPTH=4, in_ready_i=0): write 0x11..0x15 -> IN_LEVEL=4, STATUS bit1=1, IN_OVF=1. Then in_ready_i=1 -> bytes 0x11..0x14 out in order, 4 in_irq_o pulses, IN_EMPTY_EV=1.
- OUT fill and backpressure (OUT_DEPTH=4): drive 0xA0..0xA5 -> out_ready_o=0 after 4 accepts, OUT_LEVEL=4. Reading addr 3 five times -> 0xA0..0xA3, then 0x00 with OUT_UNF=1.
- Wrap-around: 10 push/pop rounds of 3 bytes with DEPTH=4 -> data order preserved, level returns to 0.
- Simultaneous: OUT full, MCU pop and out_valid_i in the same cycle -> pop only. Next cycle out_ready_o=1 and the following push is accepted; level stays 4.
- IRQ: set IRQ_EN=0x02, push an OUT byte -> irq_o=1. Write 0x02 to addr 6 in the same cycle as a new push -> flag stays 1. A later clear -> irq_o=0.

Source files
------------

// File: rtl/fifo_if_buf.sv
// MCU register interface bridging to USB_CDC byte streams through parametrised IN/OUT FIFOs.
// Define FIFO_IF_BUF_IRQ_EN to build the IRQ_EN/IRQ_FLAGS interrupt controller and irq_o.
module fifo_if_buf #(
    parameter int unsigned IN_DEPTH  = 16,
    parameter int unsigned OUT_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       sel_i,
    input  logic       read_i,
    input  logic       write_i,
    input  logic [2:0] addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       in_irq_o,
    output logic       out_irq_o,
    output logic       irq_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i,
    input  logic [7:0] out_data_i,
    input  logic       out_valid_i,
    output logic       out_ready_o
);

    localparam int unsigned InAw  = $clog2(IN_DEPTH);
    localparam int unsigned OutAw = $clog2(OUT_DEPTH);

    localparam logic [InAw:0]  InFull  = IN_DEPTH[InAw:0];
    localparam logic [OutAw:0] OutFull = OUT_DEPTH[OutAw:0];

    localparam logic [2:0] AddrStatus   = 3'd0;
    localparam logic [2:0] AddrInData   = 3'd1;
    localparam logic [2:0] AddrInLevel  = 3'd2;
    localparam logic [2:0] AddrOutData  = 3'd3;
    localparam logic [2:0] AddrOutLevel = 3'd4;
`ifdef FIFO_IF_BUF_IRQ_EN
    localparam logic [2:0] AddrIrqEn    = 3'd5;
    localparam logic [2:0] AddrIrqFlags = 3'd6;
`endif

    logic [7:0]       in_mem_q [IN_DEPTH];
    logic [InAw-1:0]  in_wr_ptr_q, in_wr_ptr_d;
    logic [InAw-1:0]  in_rd_ptr_q, in_rd_ptr_d;
    logic [InAw:0]    in_level_q, in_level_d;

    logic [7:0]       out_mem_q [OUT_DEPTH];
    logic [OutAw-1:0] out_wr_ptr_q, out_wr_ptr_d;
    logic [OutAw-1:0] out_rd_ptr_q, out_rd_ptr_d;
    logic [OutAw:0]   out_level_q, out_level_d;

    logic [7:0]       data_q, data_d;
    logic             in_irq_q, in_irq_d;
    logic             out_irq_q, out_irq_d;

    logic             mcu_rd, mcu_wr;
    logic             in_full, in_empty, out_full, out_empty;
    logic             in_push, in_pop, out_push, out_pop;
    logic [7:0]       out_head;

    assign mcu_rd    = sel_i & read_i;
    assign mcu_wr    = sel_i & write_i;

    assign in_empty  = (in_level_q == '0);
    assign in_full   = (in_level_q == InFull);
    assign out_empty = (out_level_q == '0);
    assign out_full  = (out_level_q == OutFull);

    // Fullness is the registered state, so a same-cycle consume never rescues a push.
    assign in_push   = mcu_wr && (addr_i == AddrInData) && !in_full;
    assign in_pop    = !in_empty && in_ready_i;
    assign out_push  = out_valid_i && !out_full;
    assign out_pop   = mcu_rd && (addr_i == AddrOutData) && !out_empty;

    assign out_head  = out_mem_q[out_rd_ptr_q];

    assign in_valid_o  = !in_empty;
    assign in_data_o   = in_empty ? 8'h00 : in_mem_q[in_rd_ptr_q];
    assign out_ready_o = !out_full;
    assign data_o      = data_q;
    assign in_irq_o    = in_irq_q;
    assign out_irq_o   = out_irq_q;

    always_comb begin
        in_wr_ptr_d  = in_wr_ptr_q;
        in_rd_ptr_d  = in_rd_ptr_q;
        in_level_d   = in_level_q;
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        out_level_d  = out_level_q;

        if (in_push) in_wr_ptr_d = in_wr_ptr_q + 1'b1;
        if (in_pop)  in_rd_ptr_d = in_rd_ptr_q + 1'b1;
        if (in_push && !in_pop) begin
            in_level_d = in_level_q + 1'b1;
        end else if (!in_push && in_pop) begin
            in_level_d = in_level_q - 1'b1;
        end

        if (out_push) out_wr_ptr_d = out_wr_ptr_q + 1'b1;
        if (out_pop)  out_rd_ptr_d = out_rd_ptr_q + 1'b1;
        if (out_push && !out_pop) begin
            out_level_d = out_level_q + 1'b1;
        end else if (!out_push && out_pop) begin
            out_level_d = out_level_q - 1'b1;
        end

        in_irq_d  = in_pop;
        out_irq_d = out_push;
    end

`ifdef FIFO_IF_BUF_IRQ_EN
    logic [3:0] irq_en_q, irq_en_d;
    logic [3:0] irq_flags_q, irq_flags_d;
    logic [3:0] irq_set, irq_clr;
    logic       in_empty_ev, out_data_ev, in_ovf_ev, out_unf_ev;

    // A pop only empties the buffer when no push lands in the same cycle.
    assign in_empty_ev = in_pop && !in_push && (in_level_q == {{InAw{1'b0}}, 1'b1});
    assign out_data_ev = out_push;
    assign in_ovf_ev   = mcu_wr && (addr_i == AddrInData) && in_full;
    assign out_unf_ev  = mcu_rd && (addr_i == AddrOutData) && out_empty;

    always_comb begin
        irq_set     = {out_unf_ev, in_ovf_ev, out_data_ev, in_empty_ev};
        irq_clr     = (mcu_wr && (addr_i == AddrIrqFlags)) ? data_i[3:0] : 4'h0;
        irq_en_d    = (mcu_wr && (addr_i == AddrIrqEn)) ? data_i[3:0] : irq_en_q;
        irq_flags_d = (irq_flags_q & ~irq_clr) | irq_set;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            irq_en_q    <= 4'h0;
            irq_flags_q <= 4'h0;
        end else begin
            irq_en_q    <= irq_en_d;
            irq_flags_q <= irq_flags_d;
        end
    end

    assign irq_o = |(irq_flags_q & irq_en_q);
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        data_d = data_q;
        if (mcu_rd) begin
            case (addr_i)
                AddrStatus:   data_d = {4'b0000, out_full, out_empty, in_full, in_empty};
                AddrInLevel:  data_d = 8'(in_level_q);
                AddrOutData:  data_d = out_empty ? 8'h00 : out_head;
                AddrOutLevel: data_d = 8'(out_level_q);
`ifdef FIFO_IF_BUF_IRQ_EN
                AddrIrqEn:    data_d = {4'b0000, irq_en_q};
                AddrIrqFlags: data_d = {4'b0000, irq_flags_q};
`endif
                default:      data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_level_q   <= '0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_level_q  <= '0;
            data_q       <= 8'h00;
            in_irq_q     <= 1'b0;
            out_irq_q    <= 1'b0;
        end else begin
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_level_q   <= in_level_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_level_q  <= out_level_d;
            data_q       <= data_d;
            in_irq_q     <= in_irq_d;
            out_irq_q    <= out_irq_d;
        end
    end

    // Storage needs no reset: every read path is masked by the registered levels.
    always_ff @(posedge clk_i) begin
        if (in_push)  in_mem_q[in_wr_ptr_q]   <= data_i;
        if (out_push) out_mem_q[out_wr_ptr_q] <= out_data_i;
    end

endmodule

// File: tb/tb_fifo_if_buf.sv
// Randomised plus directed bench for fifo_if_buf: queue-based reference model feeds a
// scoreboard that a negedge monitor drains against data_o, the IN stream and the irq outputs.
module tb_fifo_if_buf;

    localparam int unsigned Depth = 4;

    logic       clk_i       = 1'b0;
    logic       rstn_i      = 1'b0;
    logic       sel_i       = 1'b0;
    logic       read_i      = 1'b0;
    logic       write_i     = 1'b0;
    logic [2:0] addr_i      = 3'd0;
    logic [7:0] data_i      = 8'h00;
    logic       in_ready_i  = 1'b0;
    logic [7:0] out_data_i  = 8'h00;
    logic       out_valid_i = 1'b0;
    logic [7:0] data_o;
    logic       in_irq_o;
    logic       out_irq_o;
    logic       irq_o;
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       out_ready_o;

    fifo_if_buf #(
        .IN_DEPTH (Depth),
        .OUT_DEPTH(Depth)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .sel_i      (sel_i),
        .read_i     (read_i),
        .write_i    (write_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .in_irq_o   (in_irq_o),
        .out_irq_o  (out_irq_o),
        .irq_o      (irq_o),
        .in_data_o  (in_data_o),
        .in_valid_o (in_valid_o),
        .in_ready_i (in_ready_i),
        .out_data_i (out_data_i),
        .out_valid_i(out_valid_i),
        .out_ready_o(out_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: buffers as queues, flags/enables as plain bit vectors.
    byte unsigned m_in[$];
    byte unsigned m_out[$];
    byte unsigned exp_in[$];
    byte unsigned exp_rd[$];
    logic [3:0]   m_en        = 4'h0;
    logic [3:0]   m_flags     = 4'h0;
    bit           m_rd_done   = 1'b0;
    bit           m_in_pulse  = 1'b0;
    bit           m_out_pulse = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in.delete();
        m_out.delete();
        exp_in.delete();
        exp_rd.delete();
        m_en        = 4'h0;
        m_flags     = 4'h0;
        m_rd_done   = 1'b0;
        m_in_pulse  = 1'b0;
        m_out_pulse = 1'b0;
    endtask

    task automatic model_step();
        int         in_n;
        int         out_n;
        bit         rd, wr, in_full, out_full, in_pop, in_push, out_push;
        logic [7:0] rv;
        logic [3:0] set, clr;
        in_n     = m_in.size();
        out_n    = m_out.size();
        rd       = sel_i && read_i;
        wr       = sel_i && write_i;
        in_full  = (in_n == Depth);
        out_full = (out_n == Depth);
        in_pop   = (in_n != 0) && in_ready_i;
        in_push  = wr && (addr_i == 3'd1) && !in_full;
        out_push = out_valid_i && !out_full;
        set      = 4'h0;
        clr      = 4'h0;
        rv       = 8'h00;
        if (wr && addr_i == 3'd1 && in_full) set[2] = 1'b1;
        if (in_pop && !in_push && in_n == 1) set[0] = 1'b1;
        if (out_push) set[1] = 1'b1;
        if (rd) begin
            case (addr_i)
                3'd0: rv = {4'b0000, out_full, out_n == 0, in_full, in_n == 0};
                3'd2: rv = 8'(in_n);
                3'd3: begin
                    if (out_n == 0) set[3] = 1'b1;
                    else rv = m_out.pop_front();
                end
                3'd4: rv = 8'(out_n);
`ifdef FIFO_IF_BUF_IRQ_EN
                3'd5: rv = {4'b0000, m_en};
                3'd6: rv = {4'b0000, m_flags};
`endif
                default: rv = 8'h00;
            endcase
            exp_rd.push_back(rv);
        end
        m_rd_done = rd;
        if (in_pop) void'(m_in.pop_front());
        if (in_push) begin
            m_in.push_back(data_i);
            exp_in.push_back(data_i);
        end
        if (out_push) m_out.push_back(out_data_i);
        if (wr && addr_i == 3'd5) m_en = data_i[3:0];
        if (wr && addr_i == 3'd6) clr = data_i[3:0];
        m_flags     = (m_flags & ~clr) | set;
        m_in_pulse  = in_pop;
        m_out_pulse = out_push;
    endtask

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) model_reset();
        else model_step();
    end

    // Monitor: compares DUT outputs against scoreboard entries mid-cycle.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (m_rd_done) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_scoreboard: got data_o %02h expected no read", data_o);
                end else begin
                    check("data_o", data_o, exp_rd.pop_front());
                end
            end
            if (in_valid_o && in_ready_i) begin
                if (exp_in.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL in_scoreboard: got in_data_o %02h expected no byte", in_data_o);
                end else begin
                    check("in_data_o", in_data_o, exp_in.pop_front());
                end
            end
            check("in_valid_o", in_valid_o, m_in.size() != 0);
            check("out_ready_o", out_ready_o, m_out.size() != Depth);
            check("in_irq_o", in_irq_o, m_in_pulse);
            check("out_irq_o", out_irq_o, m_out_pulse);
`ifdef FIFO_IF_BUF_IRQ_EN
            check("irq_o", irq_o, |(m_flags & m_en));
`else
            check("irq_o", irq_o, 1'b0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        sel_i   = 1'b1;
        write_i = 1'b1;
        read_i  = 1'b0;
        addr_i  = a;
        data_i  = d;
        tick();
        sel_i   = 1'b0;
        write_i = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a);
        sel_i   = 1'b1;
        read_i  = 1'b1;
        write_i = 1'b0;
        addr_i  = a;
        tick();
        sel_i   = 1'b0;
        read_i  = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("reset data_o", data_o, 8'h00);
        check("reset in_valid_o", in_valid_o, 1'b0);
        check("reset in_data_o", in_data_o, 8'h00);
        check("reset out_ready_o", out_ready_o, 1'b1);
        check("reset irq_o", irq_o, 1'b0);
        rstn_i = 1'b1;
        tick();
        bus_read(3'd0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) bus_write(3'd1, 8'(8'h30 + i));
        #2 rstn_i = 1'b0;
        #1;
        check("midrst in_valid_o", in_valid_o, 1'b0);
        check("midrst out_ready_o", out_ready_o, 1'b1);
        check("midrst in_irq_o", in_irq_o, 1'b0);
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        bus_read(3'd0);
        bus_read(3'd2);
        bus_write(3'd5, 8'h0F);

        // IN fill and overflow, then drain
        for (int i = 0; i < 5; i++) bus_write(3'd1, 8'(8'h11 + i));
        bus_read(3'd2);
        bus_read(3'd0);
        bus_read(3'd6);
        in_ready_i = 1'b1;
        repeat (6) tick();
        in_ready_i = 1'b0;
        bus_read(3'd6);
        bus_write(3'd6, 8'h0F);

        // OUT fill, backpressure, underflow
        out_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            out_data_i = 8'(8'hA0 + i);
            tick();
        end
        out_valid_i = 1'b0;
        bus_read(3'd4);
        for (int i = 0; i < 5; i++) bus_read(3'd3);
        bus_read(3'd6);
        bus_write(3'd6, 8'h0F);

        // Wrap-around on both buffers
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 3; i++) bus_write(3'd1, 8'($urandom));
            in_ready_i = 1'b1;
            repeat (4) tick();
            in_ready_i = 1'b0;
            out_valid_i = 1'b1;
            for (int i = 0; i < 3; i++) begin
                out_data_i = 8'($urandom);
                tick();
            end
            out_valid_i = 1'b0;
            for (int i = 0; i < 3; i++) bus_read(3'd3);
        end
        bus_read(3'd2);
        bus_read(3'd4);

        // Simultaneous pop and push on a full OUT buffer
        out_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            out_data_i = 8'(8'hB0 + i);
            tick();
        end
        out_data_i = 8'hC0;
        sel_i      = 1'b1;
        read_i     = 1'b1;
        addr_i     = 3'd3;
        tick();
        sel_i      = 1'b0;
        read_i     = 1'b0;
        out_data_i = 8'hC1;
        tick();
        out_valid_i = 1'b0;
        bus_read(3'd4);
        for (int i = 0; i < 4; i++) bus_read(3'd3);

        // IRQ masking, set-wins-over-clear, later clear
        bus_write(3'd6, 8'h0F);
        bus_write(3'd5, 8'h02);
        out_valid_i = 1'b1;
        out_data_i  = 8'h55;
        tick();
        out_data_i  = 8'h56;
        bus_write(3'd6, 8'h02);
        out_valid_i = 1'b0;
        bus_read(3'd6);
        bus_write(3'd6, 8'h02);
        bus_read(3'd6);
        bus_read(3'd5);
        bus_read(3'd3);
        bus_read(3'd3);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int op;
            op          = int'($urandom_range(0, 3));
            sel_i       = ($urandom_range(0, 7) != 0);
            read_i      = (op == 1);
            write_i     = (op == 2);
            addr_i      = 3'($urandom);
            data_i      = 8'($urandom);
            in_ready_i  = ($urandom_range(0, 2) != 0);
            out_valid_i = ($urandom_range(0, 1) != 0);
            out_data_i  = 8'($urandom);
            tick();
        end
        sel_i       = 1'b0;
        read_i      = 1'b0;
        write_i     = 1'b0;
        out_valid_i = 1'b0;
        in_ready_i  = 1'b1;
        repeat (Depth + 2) tick();
        bus_read(3'd0);
        bus_read(3'd2);
        bus_read(3'd6);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
